// File: rtl/switch_debounce_toggle.sv
// Switch conditioning front-end: 2-FF synchroniser, per-channel debounce counter,
// silent power-up load of the clean levels, and commit pulses with parity.
module switch_debounce_toggle #(
   parameter int          N_SW      = 3,
   parameter int          DB_BITS   = 20,
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] S_raw,
   output logic [N_SW-1:0] S_db,
   output logic [N_SW-1:0] chg,
   output logic            toggle,
   output logic            parity,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_LOAD0 = 2'd0,
      ST_LOAD1 = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   typedef logic [DB_BITS-1:0] cnt_t;

   localparam cnt_t CNT_LAST = cnt_t'(DB_CYCLES - 1);

   state_e          state_q, state_d;
   logic            rel_q, rel_d;
   logic [N_SW-1:0] sync1_q, sync2_q;
   logic [N_SW-1:0] s_db_q, s_db_d;
   logic [N_SW-1:0] chg_q, chg_d;
   logic            toggle_q, toggle_d;
   cnt_t            cnt_q [N_SW];
   cnt_t            cnt_d [N_SW];
   logic            load_en, run_en;
   logic [N_SW-1:0] cnt_nz;

   // rel_q holds LOAD0 for one extra edge after reset release, so the
   // synchroniser is full before LOAD1 copies it into S_db.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD0;
         rel_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
         state_q <= state_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      state_d = state_q;
      rel_d   = 1'b0;
      case (state_q)
         ST_LOAD0: if (!rel_q) state_d = ST_LOAD1;
         ST_LOAD1: state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_LOAD0;
      endcase
   end

   always_comb begin
      load_en = (state_q == ST_LOAD1);
      run_en  = (state_q == ST_RUN);
   end

   always_comb begin
      s_db_d = s_db_q;
      chg_d  = '0;
      for (int i = 0; i < N_SW; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (load_en) begin
         s_db_d = sync2_q;
         for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
         end
      end else if (run_en) begin
         for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] == s_db_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               s_db_d[i] = sync2_q[i];
               chg_d[i]  = 1'b1;
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
         end
      end
      toggle_d = |chg_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         s_db_q   <= '0;
         chg_q    <= '0;
         toggle_q <= 1'b0;
         // NOTE: counters are discrete flops, not a RAM, so they take the async reset.
         for (int i = 0; i < N_SW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= S_raw;
         sync2_q  <= sync1_q;
         s_db_q   <= s_db_d;
         chg_q    <= chg_d;
         toggle_q <= toggle_d;
         for (int i = 0; i < N_SW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      cnt_nz = '0;
      for (int i = 0; i < N_SW; i++) begin
         cnt_nz[i] = (cnt_q[i] != '0);
      end
   end

   assign S_db   = s_db_q;
   assign chg    = chg_q;
   assign toggle = toggle_q;
   assign parity = ^s_db_q;
   assign busy   = (state_q != ST_RUN) || (|cnt_nz);

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Bench for switch_debounce_toggle: directed table and corner sequences plus
// random stimulus, all checked every cycle against a window-based reference model.
module tb_switch_debounce_toggle;

   localparam int N_SW      = 3;
   localparam int DB_BITS   = 20;
   localparam int DB_CYCLES = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_SW-1:0] S_raw;
   logic [N_SW-1:0] S_db;
   logic [N_SW-1:0] chg;
   logic            toggle;
   logic            parity;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   switch_debounce_toggle #(
      .N_SW      (N_SW),
      .DB_BITS   (DB_BITS),
      .DB_CYCLES (DB_CYCLES)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .S_raw  (S_raw),
      .S_db   (S_db),
      .chg    (chg),
      .toggle (toggle),
      .parity (parity),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] raw;
      logic [2:0] db;
      logic [2:0] chg;
      logic       tog;
      logic       par;
      logic       busy;
   } vec_t;

   vec_t tbl [7];

   // Reference model: a commit happens when the last DB_CYCLES synchronised
   // samples seen in RUN all differ from the clean level.
   int              m_k;
   logic [N_SW-1:0] m_hist [$];
   logic [N_SW-1:0] m_db;
   logic [N_SW-1:0] m_chg;
   logic            m_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
   endtask

   function automatic logic [N_SW-1:0] sync_at(input int j);
      if (j >= 3) return m_hist[j-3];
      return '0;
   endfunction

   task automatic model_reset();
      m_k = 0;
      m_hist.delete();
      m_db   = '0;
      m_chg  = '0;
      m_busy = 1'b1;
   endtask

   task automatic model_edge(input logic [N_SW-1:0] raw);
      logic [N_SW-1:0] v;
      logic            all_diff;
      m_k++;
      m_hist.push_back(raw);
      m_chg = '0;
      if (m_k == 3) begin
         m_db = sync_at(3);
      end else if (m_k >= DB_CYCLES + 3) begin
         for (int ch = 0; ch < N_SW; ch++) begin
            all_diff = 1'b1;
            for (int j = m_k - DB_CYCLES + 1; j <= m_k; j++) begin
               v = sync_at(j);
               if (v[ch] == m_db[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
               m_db[ch]  = ~m_db[ch];
               m_chg[ch] = 1'b1;
            end
         end
      end
      m_busy = (m_k < 3) ? 1'b1 : |(sync_at(m_k) ^ m_db);
   endtask

   function automatic logic [31:0] dut_vec();
      return {23'd0, S_db, chg, toggle, parity, busy};
   endfunction

   function automatic logic [31:0] model_vec();
      return {23'd0, m_db, m_chg, |m_chg, ^m_db, m_busy};
   endfunction

   task automatic step(input string name);
      @(posedge clk);
      model_edge(S_raw);
      @(negedge clk);
      check(name, dut_vec(), model_vec());
   endtask

   task automatic async_reset(input logic [N_SW-1:0] raw);
      #2;
      rst   = 1'b1;
      S_raw = raw;
      #1;
      check("async_reset", dut_vec(), 32'b000_000_0_0_1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int          togs;
      int          commit_at;
      logic [2:0]  chg_seen;

      tbl[0] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{3'b001, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0};

      // Power-up with switches 0 and 2 already on: loads silently.
      rst   = 1'b1;
      S_raw = 3'b101;
      model_reset();
      #12;
      check("reset_state", dut_vec(), 32'b000_000_0_0_1);
      @(negedge clk);
      rst = 1'b0;
      step("pwr_edge1");
      check("busy_edge1", busy, 1);
      step("pwr_edge2");
      check("busy_edge2", busy, 1);
      step("pwr_edge3");
      check("busy_edge3", busy, 0);
      check("pwr_db", S_db, 3'b101);
      check("pwr_parity", parity, 0);
      togs = 0;
      for (int i = 0; i < 5; i++) begin
         step("pwr_idle");
         if (toggle) togs++;
      end
      check("pwr_no_toggle", togs, 0);

      // Two channels commit on the same edge: one toggle, parity unchanged.
      S_raw    = 3'b000;
      togs     = 0;
      chg_seen = '0;
      for (int i = 0; i < 8; i++) begin
         step("dual_flip");
         if (toggle) begin
            togs++;
            chg_seen = chg;
         end
      end
      check("dual_toggles", togs, 1);
      check("dual_chg", chg_seen, 3'b101);
      check("dual_db", S_db, 3'b000);
      check("dual_parity", parity, 0);

      // Single-channel commit, cycle by cycle.
      for (int i = 0; i < 7; i++) begin
         S_raw = tbl[i].raw;
         step("tbl_model");
         check($sformatf("tbl_row%0d", i), dut_vec(),
               {23'd0, tbl[i].db, tbl[i].chg, tbl[i].tog, tbl[i].par, tbl[i].busy});
      end

      // Glitch on channel 1 lasting DB_CYCLES-1 synced cycles is rejected.
      S_raw = 3'b011;
      togs  = 0;
      for (int i = 0; i < 3; i++) begin
         step("glitch_hi");
         if (toggle) togs++;
      end
      S_raw = 3'b001;
      for (int i = 0; i < 8; i++) begin
         step("glitch_lo");
         if (toggle) togs++;
      end
      check("glitch_toggles", togs, 0);
      check("glitch_db", S_db, 3'b001);
      check("glitch_busy", busy, 0);

      // Bouncing channel 1: five flips two cycles apart, then stable high.
      togs = 0;
      for (int f = 0; f < 5; f++) begin
         S_raw[1] = ~S_raw[1];
         for (int i = 0; i < 2; i++) begin
            step("bounce");
            if (chg[1]) togs++;
         end
      end
      commit_at = -1;
      for (int i = 1; i <= 10; i++) begin
         step("bounce_hold");
         if (chg[1]) begin
            togs++;
            if (commit_at < 0) commit_at = i + 2;
         end
      end
      check("bounce_commits", togs, 1);
      check("bounce_latency", commit_at, 6);
      check("bounce_db", S_db, 3'b011);

      // Reset mid-debounce on channel 2 discards progress; new level loads silently.
      S_raw = 3'b111;
      for (int i = 0; i < 4; i++) step("pre_reset");
      check("pre_reset_busy", busy, 1);
      async_reset(3'b111);
      togs = 0;
      for (int i = 0; i < 3; i++) begin
         step("reload");
         if (toggle) togs++;
      end
      check("reload_toggles", togs, 0);
      check("reload_db", S_db, 3'b111);
      check("reload_parity", parity, 1);

      // Random stimulus with one reset in the middle.
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < N_SW; b++) begin
            if ($urandom_range(5, 0) == 0) S_raw[b] = ~S_raw[b];
         end
         if (c == 200) async_reset(3'($urandom_range(7, 0)));
         step("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
